sim_ctrl: RTL and testbench
===========================

SIM_CTRL -- requirements
Module: sim_ctrl

Interface
REQ-001 Parameter ADDR_BASE, default 32'h1000_0000, base of the 16-byte register window.
REQ-002 Parameter FIFO_DEPTH, default 8, console FIFO entries (power of two, >=2).
REQ-003 Parameter TIMEOUT_CYCLES, default 100000, watchdog limit in clk cycles.
REQ-004 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 req_valid  in  1  core load/store request present.
REQ-007 req_ready  out  1  request accepted this cycle when high with req_valid.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data.
REQ-011 req_wstrb  in  4  store byte enables.
REQ-012 rsp_valid  out  1  response strobe for an accepted request.
REQ-013 rsp_rdata  out  32  load data, valid with rsp_valid.
REQ-014 debug_value  out  32  last value written to DEBUG.
REQ-015 test_done  out  1  test finished (pass, fail or timeout).
REQ-016 test_pass  out  1  qualified by test_done.
REQ-017 test_code  out  31  exit code.
REQ-018 console_valid / console_data[7:0] out, console_ready in: FIFO drain port, transfer on valid&ready.

Function
REQ-019 Register map (offset from ADDR_BASE): 0x0 TOHOST, 0x4 DEBUG, 0x8 CONSOLE, 0xC CYCLE; addr[1:0] ignored; outside the window, stores are dropped and loads return 0.
REQ-020 req_ready SHALL be 1 except for a CONSOLE store while the FIFO is full; a same-cycle pop does not bypass.
REQ-021 rsp_valid SHALL pulse exactly one cycle after every accepted request; rsp_rdata is 0 for stores.
REQ-022 TOHOST store with wstrb=4'hF in RUN: test_done=1, test_pass=(wdata==1), test_code=wdata[31:1], state->DONE; partial strobes are ignored.
REQ-023 TOHOST load returns the last accepted TOHOST word (0 after reset).
REQ-024 DEBUG store updates debug_value per byte strobe; load returns debug_value.
REQ-025 CONSOLE store pushes wdata[7:0]; load returns {count in [k:1], full in [0]}, zero-extended.
REQ-026 CYCLE load returns a 32-bit free-running count incremented every cycle in RUN, frozen in DONE/TIMEOUT, wraps modulo 2^32.
REQ-027 States: RUN -> DONE (REQ-022); RUN -> TIMEOUT (REQ-031); DONE/TIMEOUT are absorbing until reset; TOHOST stores there are ignored (first result wins).
REQ-028 Console FIFO keeps operating in every state; console_valid = not empty; data appears in push order.
REQ-029 Empty FIFO: console_valid=0, console_data holds its last value.

Reset
REQ-030 rst low at an edge: state=RUN, FIFO emptied, cycle=0, debug_value=0, test_done=0, test_pass=0, test_code=0, rsp_valid=0, rsp_rdata=0; an in-flight request is discarded with no response.

Configuration
REQ-031 With SIM_CTRL_WATCHDOG_EN defined: in RUN, when cycle==TIMEOUT_CYCLES-1, next state=TIMEOUT, test_done=1, test_pass=0, test_code=all ones. A same-cycle TOHOST store takes precedence.
REQ-032 Without SIM_CTRL_WATCHDOG_EN: no TIMEOUT state or comparator; the test never self-terminates.

Structure
REQ-033 Package sim_ctrl_pkg SHALL hold the register offsets, the state encoding and the timeout exit code.
REQ-034 Sub-module sim_ctrl_fifo (synchronous FIFO, full/empty/count) SHALL implement the console buffer.

Verification
REQ-035 Store 32'h1 to base+0x0 -> next cycle test_done=1, test_pass=1, test_code=0; a later store of 32'h7 leaves the outputs unchanged.
REQ-036 Store 32'h0000_00AB with wstrb=4'b0001 to base+0x4, then a load -> debug_value=32'hAB, rsp_rdata=32'hAB one cycle after acceptance.
REQ-037 With console_ready=0, 9 stores to base+0x8 -> req_ready=0 on the 9th; raise console_ready -> bytes drain in order and the 9th is accepted.
REQ-038 With the macro defined and TIMEOUT_CYCLES=20, no TOHOST store -> test_done=1, test_pass=0, test_code=31'h7FFF_FFFF after 20 cycles; CYCLE load returns 19.
REQ-039 Assert rst mid-run with a FIFO of 3 entries and test_done=1 -> all outputs reach their reset values at the next edge.

Source files
------------

// File: rtl/sim_ctrl_pkg.sv
// sim_ctrl_pkg: shared definitions for the simulation-control block.
// Holds the register word offsets, the controller state encoding, the
// watchdog exit code and the byte-merge helper used for strobed stores.
// The TIMEOUT state only exists when SIM_CTRL_WATCHDOG_EN is defined.
package sim_ctrl_pkg;

  // Register word index, taken from address bits [3:2] inside the window
  localparam logic [1:0] REG_TOHOST  = 2'd0;  // byte offset 0x0
  localparam logic [1:0] REG_DEBUG   = 2'd1;  // byte offset 0x4
  localparam logic [1:0] REG_CONSOLE = 2'd2;  // byte offset 0x8
  localparam logic [1:0] REG_CYCLE   = 2'd3;  // byte offset 0xC

  // Exit code reported when the watchdog ends the test
  localparam logic [30:0] TIMEOUT_CODE = 31'h7FFF_FFFF;

`ifdef SIM_CTRL_WATCHDOG_EN
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DONE    = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DONE = 2'd1
  } state_e;
`endif

  // Replace only the bytes of old_v whose strobe bit is set
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_v[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_v[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sim_ctrl_fifo.sv
// sim_ctrl_fifo: synchronous console byte FIFO with full/empty/count.
// When empty, head_o keeps showing the most recently popped byte.
module sim_ctrl_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [7:0]    push_data_i,
  input  logic          pop_i,
  output logic [7:0]    head_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [AW:0]   count_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic [7:0]    last_q;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign count_o   = count_q;
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;
  assign head_o    = empty_o ? last_q : mem_q[rd_ptr_q];

  // Next occupancy from the accepted push/pop pair
  always_comb begin
    count_d = count_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers, occupancy and the last-popped byte
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= 8'h00;
    end else begin
      count_q <= count_d;
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        last_q   <= mem_q[rd_ptr_q];
      end
    end
  end

endmodule

// File: rtl/sim_ctrl.sv
// sim_ctrl: memory-mapped simulation controller (TOHOST, DEBUG, CONSOLE,
// CYCLE) in a 16-byte window at ADDR_BASE.
// Optional watchdog: define SIM_CTRL_WATCHDOG_EN to end the test with an
// all-ones exit code once the cycle counter reaches TIMEOUT_CYCLES-1.
module sim_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE      = 32'h1000_0000,
  parameter int          FIFO_DEPTH     = 8,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [31:0] debug_value,
  output logic        test_done,
  output logic        test_pass,
  output logic [30:0] test_code,
  output logic        console_valid,
  output logic [7:0]  console_data,
  input  logic        console_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
      (TIMEOUT_CYCLES < 1)) begin : g_bad_params
    $error("sim_ctrl: FIFO_DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
  end

`ifdef SIM_CTRL_WATCHDOG_EN
  localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES - 1);
`endif

  state_e        state_q;
  logic [31:0]   cycle_q;
  logic [31:0]   tohost_q;
  logic [31:0]   debug_q;
  logic          done_q;
  logic          pass_q;
  logic [30:0]   code_q;
  logic          rsp_valid_q;
  logic [31:0]   rsp_rdata_q;

  logic          hit_s;
  logic [1:0]    sel_s;
  logic          console_st_s;
  logic          accept_s;
  logic          push_s;
  logic          pop_s;
  logic          tohost_go_s;
  logic          debug_st_s;
  logic [31:0]   load_data_s;
  logic [31:0]   status_s;
  logic          fifo_empty_s;
  logic          fifo_full_s;
  logic [CW-1:0] fifo_count_s;
  logic          unused_addr_s;

  // Address decode: window is 16-byte aligned, byte lane bits ignored
  assign hit_s         = (req_addr[31:4] == ADDR_BASE[31:4]);
  assign sel_s         = req_addr[3:2];
  assign unused_addr_s = ^req_addr[1:0];

  // Only a console push into a full FIFO stalls; a concurrent pop does not help
  assign console_st_s = req_we && hit_s && (sel_s == REG_CONSOLE);
  assign req_ready    = !(console_st_s && fifo_full_s);
  assign accept_s     = req_valid && req_ready;
  assign push_s       = accept_s && console_st_s;
  assign pop_s        = !fifo_empty_s && console_ready;
  assign debug_st_s   = accept_s && req_we && hit_s && (sel_s == REG_DEBUG);
  assign tohost_go_s  = accept_s && req_we && hit_s && (sel_s == REG_TOHOST) &&
                        (req_wstrb == 4'hF) && (state_q == ST_RUN);

  assign console_valid = !fifo_empty_s;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign debug_value   = debug_q;
  assign test_done     = done_q;
  assign test_pass     = pass_q;
  assign test_code     = code_q;

  sim_ctrl_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_s),
    .push_data_i (req_wdata[7:0]),
    .pop_i       (pop_s),
    .head_o      (console_data),
    .empty_o     (fifo_empty_s),
    .full_o      (fifo_full_s),
    .count_o     (fifo_count_s)
  );

  // Load data mux; console status is {count, full} zero-extended
  always_comb begin
    status_s         = 32'd0;
    status_s[CW:0]   = {fifo_count_s, fifo_full_s};
    load_data_s      = 32'd0;
    if (hit_s) begin
      case (sel_s)
        REG_TOHOST:  load_data_s = tohost_q;
        REG_DEBUG:   load_data_s = debug_q;
        REG_CONSOLE: load_data_s = status_s;
        REG_CYCLE:   load_data_s = cycle_q;
        default:     load_data_s = 32'd0;
      endcase
    end else begin
      load_data_s = 32'd0;
    end
  end

  // One-cycle response for every accepted request; stores answer zero
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      rsp_valid_q <= accept_s;
      rsp_rdata_q <= (accept_s && !req_we) ? load_data_s : 32'd0;
    end
  end

  // DEBUG register with per-byte strobes
  always_ff @(posedge clk) begin
    if (!rst) begin
      debug_q <= 32'd0;
    end else if (debug_st_s) begin
      debug_q <= merge_bytes(debug_q, req_wdata, req_wstrb);
    end
  end

  // Test-status FSM: first result wins, counter frozen once the test ends
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      cycle_q  <= 32'd0;
      tohost_q <= 32'd0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      code_q   <= 31'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (tohost_go_s) begin
            state_q  <= ST_DONE;
            tohost_q <= req_wdata;
            done_q   <= 1'b1;
            pass_q   <= (req_wdata == 32'd1);
            code_q   <= req_wdata[31:1];
          end
`ifdef SIM_CTRL_WATCHDOG_EN
          else if (cycle_q == TIMEOUT_LIMIT) begin
            state_q <= ST_TIMEOUT;
            done_q  <= 1'b1;
            pass_q  <= 1'b0;
            code_q  <= TIMEOUT_CODE;
          end
`endif
          else begin
            cycle_q <= cycle_q + 32'd1;
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sim_ctrl.sv
// tb_sim_ctrl: directed scenarios plus randomized traffic for sim_ctrl,
// checked every cycle against a queue-based behavioural model.
module tb_sim_ctrl;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 8;
  localparam int          TMO   = 20;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [31:0] debug_value;
  logic        test_done;
  logic        test_pass;
  logic [30:0] test_code;
  logic        console_valid;
  logic [7:0]  console_data;
  logic        console_ready;

  sim_ctrl #(
    .ADDR_BASE      (BASE),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_wstrb     (req_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .debug_value   (debug_value),
    .test_done     (test_done),
    .test_pass     (test_pass),
    .test_code     (test_code),
    .console_valid (console_valid),
    .console_data  (console_data),
    .console_ready (console_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  bit          m_ended;     // test finished (by TOHOST or watchdog)
  bit          m_pass;
  logic [30:0] m_code;
  logic [31:0] m_cycle;
  logic [31:0] m_debug;
  logic [31:0] m_tohost;
  logic [7:0]  m_q[$];
  logic [7:0]  m_last;
  bit          m_last_known;
  bit          m_rsp_v;
  logic [31:0] m_rsp_d;
  bit          m_acc;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          collect  = 1'b0;
  logic [7:0]  got[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd16);
  endfunction

  function automatic int reg_of(input logic [31:0] a);
    return int'((a - BASE) / 32'd4);
  endfunction

  function automatic bit model_ready();
    return !(req_we && in_win(req_addr) && reg_of(req_addr) == 2 && m_q.size() == DEPTH);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a);
    if (!in_win(a)) return 32'd0;
    case (reg_of(a))
      0: return m_tohost;
      1: return m_debug;
      2: return 32'(m_q.size() * 2 + ((m_q.size() == DEPTH) ? 1 : 0));
      default: return m_cycle;
    endcase
  endfunction

  task automatic model_reset();
    m_ended = 1'b0; m_pass = 1'b0; m_code = 31'd0; m_cycle = 32'd0;
    m_debug = 32'd0; m_tohost = 32'd0; m_q.delete();
    m_last_known = 1'b0; m_rsp_v = 1'b0; m_rsp_d = 32'd0; m_acc = 1'b0;
  endtask

  // Apply one clock edge to the model using the inputs present before it
  task automatic model_edge();
    bit was_running;
    bit ended_now;
    bit do_pop;
    bit do_push;
    if (!rst) begin
      model_reset();
      return;
    end
    was_running = !m_ended;
    ended_now   = 1'b0;
    m_acc       = req_valid && model_ready();
    do_pop      = (m_q.size() > 0) && console_ready;
    do_push     = 1'b0;
    m_rsp_v     = m_acc;
    m_rsp_d     = (m_acc && !req_we) ? model_load(req_addr) : 32'd0;
    if (m_acc && req_we && in_win(req_addr)) begin
      case (reg_of(req_addr))
        0: if (was_running && req_wstrb == 4'hF) begin
             m_ended = 1'b1; m_pass = (req_wdata == 32'd1);
             m_code = req_wdata[31:1]; m_tohost = req_wdata; ended_now = 1'b1;
           end
        1: for (int b = 0; b < 4; b++)
             if (req_wstrb[b]) m_debug[8*b +: 8] = req_wdata[8*b +: 8];
        2: do_push = 1'b1;
        default: ;
      endcase
    end
`ifdef SIM_CTRL_WATCHDOG_EN
    if (was_running && !ended_now && m_cycle == 32'(TMO - 1)) begin
      m_ended = 1'b1; m_pass = 1'b0; m_code = 31'h7FFF_FFFF; ended_now = 1'b1;
    end
`endif
    if (was_running && !ended_now) m_cycle = m_cycle + 32'd1;
    if (do_pop) begin
      m_last = m_q.pop_front();
      m_last_known = 1'b1;
    end
    if (do_push) m_q.push_back(req_wdata[7:0]);
  endtask

  task automatic check_outputs();
    check("rsp_valid", rsp_valid, m_rsp_v);
    check("rsp_rdata", rsp_rdata, m_rsp_d);
    check("debug_value", debug_value, m_debug);
    check("test_done", test_done, m_ended);
    check("test_pass", test_pass, m_pass);
    check("test_code", 32'(test_code), 32'(m_code));
    check("console_valid", console_valid, m_q.size() > 0);
    if (m_q.size() > 0) check("console_data", console_data, m_q[0]);
    else if (m_last_known) check("console_hold", console_data, m_last);
  endtask

  // One clock: check ready before the edge, model and outputs after it
  task automatic step();
    #1;
    check("req_ready", req_ready, model_ready());
    if (collect && console_valid && console_ready) got.push_back(console_data);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic drive(input bit v, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
    step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  s;
    int          r;
    rst = 1'b0; console_ready = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_wstrb = 4'h0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Reset state
    check("reset_done", test_done, 1'b0);
    check("reset_pass", test_pass, 1'b0);
    check("reset_code", 32'(test_code), 32'd0);
    check("reset_debug", debug_value, 32'd0);
    check("reset_cvalid", console_valid, 1'b0);
    check("reset_rsp", rsp_valid, 1'b0);

    // DEBUG byte store then load
    drive(1'b1, 1'b1, BASE + 32'h4, 32'h0000_00AB, 4'b0001);
    check("dbg_value", debug_value, 32'h0000_00AB);
    drive(1'b1, 1'b0, BASE + 32'h4, 32'd0, 4'h0);
    check("dbg_rsp_valid", rsp_valid, 1'b1);
    check("dbg_rsp_data", rsp_rdata, 32'h0000_00AB);

    // TOHOST pass, then a second store must not change the result
    drive(1'b1, 1'b1, BASE, 32'h1, 4'hF);
    check("pass_done", test_done, 1'b1);
    check("pass_pass", test_pass, 1'b1);
    check("pass_code", 32'(test_code), 32'd0);
    drive(1'b1, 1'b1, BASE, 32'h7, 4'hF);
    check("sticky_pass", test_pass, 1'b1);
    check("sticky_code", 32'(test_code), 32'd0);
    drive(1'b1, 1'b0, BASE + 32'h2, 32'd0, 4'h0);
    check("tohost_load", rsp_rdata, 32'h1);

    // Console back-pressure: ninth store stalls until a byte drains
    do_reset();
    console_ready = 1'b0;
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, BASE + 32'h8, 32'h10 + 32'(i), 4'h1);
    got.delete();
    collect = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = BASE + 32'h8; req_wdata = 32'h18; req_wstrb = 4'h1;
    #1;
    check("ninth_stall", req_ready, 1'b0);
    step();
    console_ready = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        step();
        seen = rsp_valid;
      end
      check("ninth_accept", seen, 1'b1);
    end
    idle(12);
    collect = 1'b0;
    check("drain_count", got.size(), 32'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < got.size()) check("drain_order", got[i], 8'h10 + 8'(i));
    end

`ifdef SIM_CTRL_WATCHDOG_EN
    // Watchdog fires after TMO cycles with no TOHOST store
    do_reset();
    idle(TMO);
    check("wd_done", test_done, 1'b1);
    check("wd_pass", test_pass, 1'b0);
    check("wd_code", 32'(test_code), 32'h7FFF_FFFF);
    drive(1'b1, 1'b0, BASE + 32'hC, 32'd0, 4'h0);
    check("wd_cycle", rsp_rdata, 32'(TMO - 1));
`endif

    // Reset mid-run with 3 queued bytes and a finished test
    do_reset();
    console_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, BASE + 32'h8, 32'h40 + 32'(i), 4'h1);
    drive(1'b1, 1'b1, BASE, 32'h5, 4'hF);
    drive(1'b1, 1'b1, BASE + 32'h4, 32'hDEAD_BEEF, 4'hF);
    check("pre_rst_done", test_done, 1'b1);
    rst = 1'b0;
    drive(1'b1, 1'b0, BASE + 32'hC, 32'd0, 4'h0);
    check("rst_done", test_done, 1'b0);
    check("rst_pass", test_pass, 1'b0);
    check("rst_code", 32'(test_code), 32'd0);
    check("rst_cvalid", console_valid, 1'b0);
    check("rst_rsp", rsp_valid, 1'b0);
    check("rst_debug", debug_value, 32'd0);
    rst = 1'b1;
    drive(1'b1, 1'b0, BASE + 32'hC, 32'd0, 4'h0);
    check("cycle_after_rst", rsp_rdata, 32'd0);

    // Randomized traffic with periodic resets
    for (int i = 0; i < 3000; i++) begin
      rst = (i % 400 == 399) ? 1'b0 : 1'b1;
      if ((i / 400) % 2 == 1) console_ready = ($urandom_range(0, 3) == 0);
      else                    console_ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      if (r < 8) a = BASE + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
      else if (r == 8) a = BASE + 32'd16 + 32'($urandom_range(0, 255));
      else a = BASE - 32'd4 - 32'($urandom_range(0, 255));
      s = 4'($urandom_range(0, 15));
      if (in_win(a) && reg_of(a) == 0) begin
        if ($urandom_range(0, 31) == 0) s = 4'hF;
        else if (s == 4'hF) s = 4'h7;
      end
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a,
            ($urandom_range(0, 3) == 0) ? 32'h1 : $urandom, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
